// File: rtl/riscv_harness_pkg.sv
// Shared types and constants for the riscv-mini harness sequencer.
package riscv_harness_pkg;

  localparam int PC_W = 33;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    RESET_HOLD,
    BUBBLE,
    WARMUP,
    ARMED,
    TRACK,
    DONE,
    ERROR
  } seq_state_t;

endpackage

// File: rtl/harness_inst_rom.sv
// Loadable instruction ROM: one write port, one registered read port, array never reset.
module harness_inst_rom #(
  parameter int NUM_INST = 8,
  parameter int ADDR_W   = 3
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [NUM_INST];

  // Read samples the array before this edge's write lands, so a colliding read sees the old word.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/riscv_harness_sequencer.sv
// Drives core reset and the icache response from a loadable ROM, and tracks one
// instruction through the pc / fe_pc / ew_pc taps with per-stage hit strobes.
module riscv_harness_sequencer
  import riscv_harness_pkg::*;
#(
  parameter int NUM_INST      = 8,
  parameter int ADDR_W        = 3,
  parameter int RESET_CYCLES  = 1,
  parameter int WARMUP_CYCLES = 8,
  parameter int TIMEOUT       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  input  logic [31:0]       icache_req_addr,
  output logic              core_reset,
  output logic              icache_resp_valid,
  output logic [31:0]       icache_resp_data,
  input  logic [PC_W-1:0]   npc,
  input  logic [PC_W-1:0]   pc,
  input  logic [PC_W-1:0]   fe_pc,
  input  logic [PC_W-1:0]   ew_pc,
  output logic [PC_W-1:0]   track_pc,
  output logic              active,
  output logic [2:0]        stage_hit,
  output logic              done,
  output logic              timeout
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] RH_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] WU_LAST = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  seq_state_t       state;
  seq_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic             start_p1;
  logic             started;
  logic             start_rise;
  logic             pc_hit;
  logic             fe_hit;
  logic             ew_hit;
  logic             arm_to_track;
  logic [31:0]      rom_rdata;

  // Fetch index uses only the word bits inside the ROM; everything else wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, icache_req_addr[31:ADDR_W+2], icache_req_addr[1:0]};

  harness_inst_rom #(
    .NUM_INST (NUM_INST),
    .ADDR_W   (ADDR_W)
  ) u_rom (
    .clock (clock),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (icache_req_addr[ADDR_W+1:2]),
    .rdata (rom_rdata)
  );

  assign start_rise   = start && !start_p1;
  assign pc_hit       = active && (pc == track_pc);
  assign fe_hit       = active && (fe_pc == track_pc);
  assign ew_hit       = active && (ew_pc == track_pc);
  assign arm_to_track = (state == ARMED) && (state_next == TRACK);

  always_comb begin
    state_next        = state;
    core_reset        = 1'b0;
    icache_resp_valid = 1'b1;
    icache_resp_data  = rom_rdata;
    case (state)
      RESET_HOLD: begin
        core_reset       = 1'b1;
        icache_resp_data = '0;
        if (cnt == RH_LAST) state_next = BUBBLE;
      end
      BUBBLE: begin
        icache_resp_valid = 1'b0;
        icache_resp_data  = '0;
        state_next        = WARMUP;
      end
      WARMUP: begin
        if (cnt == WU_LAST) state_next = ARMED;
      end
      ARMED: begin
        // A request seen earlier in the bring-up is held in started until now.
        if (started || start_rise) state_next = TRACK;
      end
      TRACK: begin
        if (ew_hit) state_next = DONE;
        else if (cnt == TO_LAST) state_next = ERROR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RESET_HOLD;
      cnt       <= '0;
      start_p1  <= 1'b0;
      started   <= 1'b0;
      track_pc  <= '0;
      active    <= 1'b0;
      stage_hit <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state    <= state_next;
      start_p1 <= start;
      if ((state_next != state) || (state == DONE) || (state == ERROR)) cnt <= '0;
      else cnt <= cnt + CNT_W'(1);

      if (arm_to_track) begin
        started  <= 1'b0;
        track_pc <= npc;
        active   <= 1'b1;
      end else if (start_rise) begin
        started <= 1'b1;
      end

      // Strobes only fire in TRACK; the retiring [2] pulse lands with the move to DONE.
      if (state == TRACK) stage_hit <= {ew_hit, fe_hit, pc_hit};
      else stage_hit <= '0;

      if (state == TRACK && ew_hit) begin
        active <= 1'b0;
        done   <= 1'b1;
      end else if (state == TRACK && state_next == ERROR) begin
        active  <= 1'b0;
        timeout <= 1'b1;
      end
    end
  end

endmodule
